// File: rtl/trace_line_reader_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the trace line reader: ASCII constants for the
// record syntax, the parser state enum, the byte classifier used by the
// next-state logic, and the longest record name the reader can compare.
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam logic [7:0] ASCII_EQ = 8'h3D;   // '='
    localparam logic [7:0] ASCII_LF = 8'h0A;   // '\n'
    localparam logic [7:0] ASCII_CR = 8'h0D;   // '\r'

    localparam int MAX_NAME = 16;

    typedef enum logic [1:0] {
        ST_NAME = 2'd0,
        ST_HEX  = 2'd1,
        ST_EMIT = 2'd2,
        ST_SKIP = 2'd3
    } state_e;

    // Syntactic role of a byte; everything that is not a delimiter is data
    typedef enum logic [1:0] {
        BC_DATA = 2'd0,
        BC_EQ   = 2'd1,
        BC_LF   = 2'd2,
        BC_CR   = 2'd3
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e c;
        case (b)
            ASCII_EQ: c = BC_EQ;
            ASCII_LF: c = BC_LF;
            ASCII_CR: c = BC_CR;
            default:  c = BC_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/trace_line_reader_if.sv
// -----------------------------------------------------------------------------
// trace_line_reader_if
// Byte-stream input handshake plus decoded-record output of the trace line
// reader.
//   in_data   [7:0]       ASCII byte from the source
//   in_valid              in_data is valid
//   in_ready              reader accepts the byte this cycle
//   out_valid             one-cycle pulse: matching record complete
//   out_data  [WIDTH-1:0] last decoded value, held between pulses
//   err                   one-cycle pulse: malformed line discarded
// master: byte source / result consumer.  slave: the reader.
// -----------------------------------------------------------------------------
interface trace_line_reader_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             err;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_valid,
        output out_data,
        output err
    );
endinterface

// File: rtl/trace_line_reader_ascii_hex_decode.sv
// -----------------------------------------------------------------------------
// ascii_hex_decode
// Purely combinational ASCII to hex-nibble decoder (0-9, a-f, A-F).
//   i_byte   [7:0]  ASCII byte
//   o_is_hex        byte is a hex digit
//   o_nib    [3:0]  nibble value (0 when o_is_hex is low)
// -----------------------------------------------------------------------------
module ascii_hex_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nib
);

    // Letters a-f / A-F share the low nibble 1..6, hence the +9 offset
    always_comb begin
        o_is_hex = 1'b0;
        o_nib    = 4'h0;
        if ((i_byte >= 8'h30) && (i_byte <= 8'h39)) begin
            o_is_hex = 1'b1;
            o_nib    = i_byte[3:0];
        end else if ((i_byte >= 8'h61) && (i_byte <= 8'h66)) begin
            o_is_hex = 1'b1;
            o_nib    = i_byte[3:0] + 4'd9;
        end else if ((i_byte >= 8'h41) && (i_byte <= 8'h46)) begin
            o_is_hex = 1'b1;
            o_nib    = i_byte[3:0] + 4'd9;
        end else begin
            o_is_hex = 1'b0;
            o_nib    = 4'h0;
        end
    end

endmodule

// File: rtl/trace_line_reader.sv
// -----------------------------------------------------------------------------
// trace_line_reader
// Parses an ASCII stream of "NAME=HEXVALUE\n" records and publishes the value
// of every well-formed record whose name equals ARGUMENT.
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   bus (slave)    in_data/in_valid/in_ready byte input,
//                  out_valid/out_data/err result output
// Parameters:
//   WIDTH     decoded value width, multiple of 4
//   ARGUMENT  record name, packed ASCII, first character in the MSBs
//   NAME_LEN  character count of ARGUMENT, 1..MAX_NAME
// -----------------------------------------------------------------------------
module trace_line_reader
    import trace_pkg::*;
#(
    parameter int                      WIDTH    = 32,
    parameter logic [8*MAX_NAME-1:0]   ARGUMENT = "0",
    parameter int                      NAME_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    trace_line_reader_if.slave   bus
);

    localparam int DIG_MAX = WIDTH / 4;
    localparam int DW      = $clog2(DIG_MAX + 1);

    // Registers
    state_e           r_state;
    logic [4:0]       r_name_cnt;   // name chars seen on this line, 0..MAX_NAME
    logic             r_name_ok;    // every name char so far equals ARGUMENT
    logic             r_match;      // current line's name equals ARGUMENT
    logic [DW-1:0]    r_dig_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_err;

    // Combinational
    state_e           w_state_nxt;
    byte_class_e      w_class;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_err;
    logic             w_is_hex;
    logic [3:0]       w_nib;
    logic [3:0]       w_arg_idx;
    logic [7:0]       w_arg_char;
    logic             w_char_hit;
    logic             w_name_match;
    logic             w_name_clr;
    logic             w_name_push;
    logic             w_enter_hex;
    logic             w_hex_push;
    logic             w_load_out;

    ascii_hex_decode u_hex (
        .i_byte   (bus.in_data),
        .o_is_hex (w_is_hex),
        .o_nib    (w_nib)
    );

    assign w_class  = classify(bus.in_data);
    assign w_accept = bus.in_valid & w_in_ready;

    // Character r_name_cnt of ARGUMENT sits NAME_LEN-1-cnt bytes above the LSB.
    // The index wraps once the name is longer than ARGUMENT, so the hit is
    // additionally qualified by the count.
    assign w_arg_idx    = 4'(NAME_LEN - 1) - r_name_cnt[3:0];
    assign w_arg_char   = ARGUMENT[{w_arg_idx, 3'b000} +: 8];
    assign w_char_hit   = (r_name_cnt < 5'(NAME_LEN)) && (bus.in_data == w_arg_char);
    assign w_name_match = (r_name_cnt == 5'(NAME_LEN)) && r_name_ok;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and error strobe for the byte accepted this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_NAME: begin
                    case (w_class)
                        BC_EQ: begin
                            if (r_name_cnt == 5'd0) begin
                                w_state_nxt = ST_SKIP;
                                w_err       = 1'b1;
                            end else begin
                                w_state_nxt = ST_HEX;
                            end
                        end
                        BC_LF: begin
                            // Empty lines are legal; a bare name is not
                            w_state_nxt = ST_NAME;
                            if (r_name_cnt == 5'd0) begin
                                w_err = 1'b0;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        BC_CR: begin
                            w_state_nxt = ST_NAME;
                        end
                        default: begin
                            if (r_name_cnt == 5'(MAX_NAME)) begin
                                w_state_nxt = ST_SKIP;
                                w_err       = 1'b1;
                            end else begin
                                w_state_nxt = ST_NAME;
                            end
                        end
                    endcase
                end
                ST_HEX: begin
                    case (w_class)
                        BC_LF: begin
                            // A record with no digits is malformed even if
                            // its name would have been filtered out
                            if (r_dig_cnt == DW'(0)) begin
                                w_state_nxt = ST_NAME;
                                w_err       = 1'b1;
                            end else if (r_match) begin
                                w_state_nxt = ST_EMIT;
                            end else begin
                                w_state_nxt = ST_NAME;
                            end
                        end
                        BC_CR: begin
                            w_state_nxt = ST_HEX;
                        end
                        default: begin
                            if (!w_is_hex || (r_dig_cnt == DW'(DIG_MAX))) begin
                                w_state_nxt = ST_SKIP;
                                w_err       = 1'b1;
                            end else begin
                                w_state_nxt = ST_HEX;
                            end
                        end
                    endcase
                end
                ST_SKIP: begin
                    if (w_class == BC_LF) begin
                        w_state_nxt = ST_NAME;
                    end else begin
                        w_state_nxt = ST_SKIP;
                    end
                end
                default: begin
                    w_state_nxt = ST_NAME;
                end
            endcase
        end else begin
            // EMIT lasts exactly one cycle and never accepts a byte
            if (r_state == ST_EMIT) begin
                w_state_nxt = ST_NAME;
            end else begin
                w_state_nxt = r_state;
            end
        end
    end

    // Handshake and datapath control strobes
    always_comb begin
        w_in_ready  = 1'b0;
        w_name_clr  = 1'b0;
        w_name_push = 1'b0;
        w_enter_hex = 1'b0;
        w_hex_push  = 1'b0;
        w_load_out  = 1'b0;
        if (rst || (r_state == ST_EMIT)) begin
            w_in_ready = 1'b0;
        end else begin
            w_in_ready = 1'b1;
        end
        // Name tracking restarts whenever the line leaves the NAME phase
        if (r_state != ST_NAME) begin
            w_name_clr = 1'b1;
        end else if (w_accept && ((w_class == BC_LF) || (w_state_nxt != ST_NAME))) begin
            w_name_clr = 1'b1;
        end else begin
            w_name_clr = 1'b0;
        end
        w_name_push = w_accept && (r_state == ST_NAME) && (w_state_nxt == ST_NAME)
                      && (w_class == BC_DATA);
        w_enter_hex = w_accept && (r_state == ST_NAME) && (w_state_nxt == ST_HEX);
        w_hex_push  = w_accept && (r_state == ST_HEX) && (w_state_nxt == ST_HEX) && w_is_hex;
        w_load_out  = (w_state_nxt == ST_EMIT);
    end

    // Line bookkeeping: name compare, hex accumulator, published outputs.
    // out_data is loaded on the edge into EMIT so it is valid with the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_name_cnt  <= 5'd0;
            r_name_ok   <= 1'b1;
            r_match     <= 1'b0;
            r_dig_cnt   <= DW'(0);
            r_acc       <= {WIDTH{1'b0}};
            r_out_data  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_name_clr) begin
                r_name_cnt <= 5'd0;
                r_name_ok  <= 1'b1;
            end else if (w_name_push) begin
                r_name_cnt <= r_name_cnt + 5'd1;
                r_name_ok  <= r_name_ok & w_char_hit;
            end else begin
                r_name_cnt <= r_name_cnt;
                r_name_ok  <= r_name_ok;
            end

            if (w_enter_hex) begin
                r_acc     <= {WIDTH{1'b0}};
                r_dig_cnt <= DW'(0);
                r_match   <= w_name_match;
            end else if (w_hex_push) begin
                r_acc     <= {r_acc[WIDTH-5:0], w_nib};
                r_dig_cnt <= r_dig_cnt + DW'(1);
            end else begin
                r_acc     <= r_acc;
                r_dig_cnt <= r_dig_cnt;
            end

            if (w_load_out) begin
                r_out_data <= r_acc;
            end else begin
                r_out_data <= r_out_data;
            end

            r_out_valid <= w_load_out;
            r_err       <= w_err;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_trace_line_reader.sv
// -----------------------------------------------------------------------------
// Bench for trace_line_reader with ARGUMENT="pc", NAME_LEN=2, WIDTH=32.
// Expected events are derived per line from the record grammar: for each
// accepted byte the model records whether it ends a matching record (and the
// value) or is the byte that makes the line malformed.
// -----------------------------------------------------------------------------
module tb_trace_line_reader;

    localparam int WIDTH = 32;
    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    trace_line_reader_if #(.WIDTH(WIDTH)) bus ();

    trace_line_reader #(
        .WIDTH    (WIDTH),
        .ARGUMENT ("pc"),
        .NAME_LEN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_out = 32'h0;
    bit          exp_err[$];
    bit          exp_emit[$];
    logic [31:0] exp_val[$];

    function automatic bytes_t str2q(input string t);
        bytes_t q;
        for (int i = 0; i < t.len(); i++) q.push_back(t[i]);
        return q;
    endfunction

    function automatic int ref_hex(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Evaluate one complete line s[a..lf] (lf is the '\n')
    function automatic void model_line(input bytes_t s, input int a, input int lf);
        bytes_t      nm;
        int          eq = -1;
        int          nd = 0;
        logic [31:0] v  = 32'h0;
        for (int i = a; i <= lf; i++) begin
            if (s[i] == 8'h0D) continue;
            if (s[i] == 8'h0A) begin
                if (nm.size() > 0) exp_err[i] = 1'b1;
                return;
            end
            if (s[i] == "=") begin
                if (nm.size() == 0) begin
                    exp_err[i] = 1'b1;
                    return;
                end
                eq = i;
                break;
            end
            if (nm.size() == 16) begin
                exp_err[i] = 1'b1;
                return;
            end
            nm.push_back(s[i]);
        end
        for (int i = eq + 1; i <= lf; i++) begin
            if (s[i] == 8'h0D) continue;
            if (s[i] == 8'h0A) begin
                if (nd == 0) exp_err[i] = 1'b1;
                else if (nm.size() == 2 && nm[0] == "p" && nm[1] == "c") begin
                    exp_emit[i] = 1'b1;
                    exp_val[i]  = v;
                end
                return;
            end
            if (ref_hex(s[i]) < 0 || nd == 8) begin
                exp_err[i] = 1'b1;
                return;
            end
            v  = (v << 4) | 32'(ref_hex(s[i]));
            nd = nd + 1;
        end
    endfunction

    function automatic void build_model(input bytes_t s);
        int start = 0;
        exp_err.delete();
        exp_emit.delete();
        exp_val.delete();
        for (int i = 0; i < s.size(); i++) begin
            exp_err.push_back(1'b0);
            exp_emit.push_back(1'b0);
            exp_val.push_back(32'h0);
        end
        for (int i = 0; i < s.size(); i++) begin
            if (s[i] == 8'h0A) begin
                model_line(s, start, i);
                start = i + 1;
            end
        end
    endfunction

    // Drive a byte stream (mode 0 back-to-back, 1 valid toggling, 2 random
    // gaps) and compare every cycle's outputs with the model.
    task automatic run_stream(input string tag, input bytes_t s, input int mode,
                              output int n_pulse, output int n_err);
        int k = 0;
        int cyc = 0;
        bit tog = 1'b0;
        bit v;
        bit acc_now;
        bit e_err;
        bit e_emit;
        build_model(s);
        n_pulse = 0;
        n_err   = 0;
        while (k < s.size()) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(99, 0) >= 30);
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? s[k] : 8'($urandom);
            @(negedge clk);
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            e_err  = acc_now ? exp_err[k]  : 1'b0;
            e_emit = acc_now ? exp_emit[k] : 1'b0;
            if (e_emit) model_out = exp_val[k];
            n_cmp++;
            if (bus.err !== e_err) begin
                n_bad++;
                $display("FAIL %s err byte %0d: got %b want %b", tag, k, bus.err, e_err);
            end
            n_cmp++;
            if (bus.out_valid !== e_emit) begin
                n_bad++;
                $display("FAIL %s out_valid byte %0d: got %b want %b", tag, k, bus.out_valid, e_emit);
            end
            n_cmp++;
            if (bus.out_data !== model_out) begin
                n_bad++;
                $display("FAIL %s out_data byte %0d: got %h want %h", tag, k, bus.out_data, model_out);
            end
            n_cmp++;
            if (bus.in_ready !== !e_emit) begin
                n_bad++;
                $display("FAIL %s in_ready byte %0d: got %b want %b", tag, k, bus.in_ready, !e_emit);
            end
            if (bus.out_valid === 1'b1) n_pulse++;
            if (bus.err === 1'b1) n_err++;
            if (acc_now) k++;
            cyc++;
            if (cyc > 4 * s.size() + 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s timeout: accepted %0d of %0d bytes", tag, k, s.size());
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset;
        bus.in_valid = 1'b1;
        bus.in_data  = "p";
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_cmp++;
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", bus.err); end
        n_cmp++;
        if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_out = 32'h0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post-reset in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset;
        #2;
        do_reset();
    endtask

    task automatic test_single_record;
        int np, ne;
        run_stream("single", str2q("pc=0040001C\n"), 0, np, ne);
        n_cmp++;
        if (np !== 1 || ne !== 0) begin n_bad++; $display("FAIL single counts: got %0d/%0d want 1/0", np, ne); end
        n_cmp++;
        if (bus.out_data !== 32'h0040001C) begin n_bad++; $display("FAIL single value: got %h want 0040001c", bus.out_data); end
    endtask

    task automatic test_filtered;
        int np, ne;
        run_stream("filter", str2q("ra=DEADBEEF\npc=ff\015\n"), 0, np, ne);
        n_cmp++;
        if (np !== 1 || ne !== 0) begin n_bad++; $display("FAIL filter counts: got %0d/%0d want 1/0", np, ne); end
        n_cmp++;
        if (bus.out_data !== 32'h000000FF) begin n_bad++; $display("FAIL filter value: got %h want 000000ff", bus.out_data); end
    endtask

    task automatic test_bad_digit;
        int np, ne;
        run_stream("baddigit", str2q("pc=12G4\npc=5\n"), 2, np, ne);
        n_cmp++;
        if (np !== 1 || ne !== 1) begin n_bad++; $display("FAIL baddigit counts: got %0d/%0d want 1/1", np, ne); end
        n_cmp++;
        if (bus.out_data !== 32'h5) begin n_bad++; $display("FAIL baddigit value: got %h want 00000005", bus.out_data); end
    endtask

    task automatic test_overflow;
        int np, ne;
        run_stream("overflow", str2q("pc=123456789\n"), 0, np, ne);
        n_cmp++;
        if (np !== 0 || ne !== 1) begin n_bad++; $display("FAIL overflow counts: got %0d/%0d want 0/1", np, ne); end
        n_cmp++;
        if (bus.out_data !== 32'h5) begin n_bad++; $display("FAIL overflow held value: got %h want 00000005", bus.out_data); end
    endtask

    task automatic test_toggle;
        int np, ne;
        run_stream("toggle", str2q("\npc=A\n"), 1, np, ne);
        n_cmp++;
        if (np !== 1 || ne !== 0) begin n_bad++; $display("FAIL toggle counts: got %0d/%0d want 1/0", np, ne); end
        n_cmp++;
        if (bus.out_data !== 32'hA) begin n_bad++; $display("FAIL toggle value: got %h want 0000000a", bus.out_data); end
    endtask

    task automatic test_midline_reset;
        int np, ne;
        run_stream("prereset", str2q("pc=12"), 0, np, ne);
        do_reset();
        run_stream("postreset", str2q("34\n"), 0, np, ne);
        n_cmp++;
        if (np !== 0 || ne !== 1) begin n_bad++; $display("FAIL postreset counts: got %0d/%0d want 0/1", np, ne); end
    endtask

    task automatic test_random_lines;
        bytes_t s;
        string  names[8] = '{"pc", "pc", "ra", "p", "pcc", "PC", "", "abcdefghijklmnopq"};
        string  hexd = "0123456789abcdefABCDEF";
        string  nm;
        int     nd, np, ne, xp, xe;
        for (int ln = 0; ln < 60; ln++) begin
            if ($urandom_range(9, 0) == 0) begin
                s.push_back(8'h0A);
                continue;
            end
            nm = names[$urandom_range(7, 0)];
            for (int i = 0; i < nm.len(); i++) s.push_back(nm[i]);
            if ($urandom_range(9, 0) != 0) s.push_back("=");
            nd = $urandom_range(9, 0);
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(14, 0) == 0) s.push_back("G");
                else s.push_back(hexd[$urandom_range(21, 0)]);
            end
            if ($urandom_range(4, 0) == 0) s.push_back(8'h0D);
            s.push_back(8'h0A);
        end
        run_stream("random", s, 2, np, ne);
        xp = 0;
        xe = 0;
        for (int i = 0; i < exp_emit.size(); i++) begin
            xp += int'(exp_emit[i]);
            xe += int'(exp_err[i]);
        end
        n_cmp++;
        if (np !== xp) begin n_bad++; $display("FAIL random pulses: got %0d want %0d", np, xp); end
        n_cmp++;
        if (ne !== xe) begin n_bad++; $display("FAIL random errs: got %0d want %0d", ne, xe); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_single_record();
        test_filtered();
        test_bad_digit();
        test_overflow();
        test_toggle();
        test_midline_reset();
        test_random_lines();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
